add_unit_arbiter: RTL and testbench

Sequencing controller and two-port round-robin arbiter for the shared 16-bit ripple carry-lookahead add/subtract unit. Two requesters, e.g. the ALU instruction path and the address/PC path, submit operand pairs. The block grants one requester at a time, latches its operands, drives and enables the adder, and waits for the adder's `ready` plus a minimum settle time. It then returns the 16-bit result and carry-out to the granted requester with a one-cycle done pulse.

---
 rtl/add_unit_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_add_unit_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/add_unit_arbiter.sv
// add_unit_arbiter: two-port round-robin arbiter and sequencer for the shared
// 16-bit add/subtract unit. One requester is granted at a time; its operands
// are latched, the adder is enabled until it reports ready (after a minimum
// settle time), and the result/carry are returned with a one-cycle done pulse.
//
// Optional feature macro: ADD_ARB_TIMEOUT_EN
//   defined   - WAIT gives up after TIMEOUT cycles and completes with err=1,
//               result=0, cout=0 (a real completion in the same cycle wins).
//   undefined - WAIT never times out, err is tied to 0, TIMEOUT is unused.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no operation; arbitrate between req0/req1
// ISSUE | operands latched, adder enabled for first cycle, wait_cnt cleared
// WAIT  | adder enabled; wait for add_ready after the minimum settle time
// DONE  | done pulse to the granted requester; grant released afterwards

module add_unit_arbiter #(
    parameter int MIN_WAIT = 2,
    parameter int TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        sub0,
    input  logic        sub1,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] result,
    output logic        cout,
    output logic        err,
    output logic        add_en,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    output logic        add_sub,
    input  logic [15:0] add_result,
    input  logic        add_cout,
    input  logic        add_ready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // A stale ready from the previous operation is ignored until wait_cnt
    // has reached MIN_WAIT-1.
    localparam logic [7:0] MIN_WAIT_M1 = 8'(MIN_WAIT - 1);

    // Out-of-range parameters are rejected at elaboration.
    if (MIN_WAIT < 1 || MIN_WAIT > 255) begin : g_bad_min_wait
        $error("add_unit_arbiter: MIN_WAIT must be in 1..255");
    end
    if (TIMEOUT < MIN_WAIT || TIMEOUT > 255) begin : g_bad_timeout
        $error("add_unit_arbiter: TIMEOUT must be in MIN_WAIT..255");
    end

    state_t      state_q;
    state_t      state_d;

    logic        last_gnt_q;
    logic        gnt0_q;
    logic        gnt1_q;
    logic [15:0] op_a_q;
    logic [15:0] op_b_q;
    logic        op_sub_q;
    logic [7:0]  wait_cnt_q;
    logic [15:0] result_q;
    logic        cout_q;

    logic        pick0;
    logic        pick1;
    logic        complete;
    logic        timed_out;
    logic        load0;
    logic        load1;
    logic        clr_wait;
    logic        inc_wait;
    logic        capture;
    logic        capture_to;
    logic        release_gnt;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Arbitration, next-state decode and per-cycle datapath controls.
    always_comb begin
        state_d     = state_q;
        load0       = 1'b0;
        load1       = 1'b0;
        clr_wait    = 1'b0;
        inc_wait    = 1'b0;
        capture     = 1'b0;
        capture_to  = 1'b0;
        release_gnt = 1'b0;

        // On a tie the requester that was not granted last time wins.
        pick0 = req0 && (!req1 || last_gnt_q);
        pick1 = req1 && (!req0 || !last_gnt_q);

        complete = (state_q == S_WAIT) && add_ready && (wait_cnt_q >= MIN_WAIT_M1);
`ifdef ADD_ARB_TIMEOUT_EN
        timed_out = (state_q == S_WAIT) && !complete
                    && (wait_cnt_q == 8'(TIMEOUT - 1));
`else
        timed_out = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (pick0) begin
                    load0   = 1'b1;
                    state_d = S_ISSUE;
                end else if (pick1) begin
                    load1   = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                clr_wait = 1'b1;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                inc_wait = 1'b1;
                if (complete) begin
                    capture = 1'b1;
                    state_d = S_DONE;
                end else if (timed_out) begin
                    capture_to = 1'b1;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                release_gnt = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Grant, operand latch, settle counter and result capture registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_q <= 1'b1;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_sub_q   <= 1'b0;
            wait_cnt_q <= '0;
            result_q   <= '0;
            cout_q     <= 1'b0;
        end else begin
            if (load0 || load1) begin
                op_a_q     <= load1 ? a1 : a0;
                op_b_q     <= load1 ? b1 : b0;
                op_sub_q   <= load1 ? sub1 : sub0;
                gnt0_q     <= load0;
                gnt1_q     <= load1;
                last_gnt_q <= load1;
            end else if (release_gnt) begin
                gnt0_q <= 1'b0;
                gnt1_q <= 1'b0;
            end

            if (clr_wait) begin
                wait_cnt_q <= '0;
            end else if (inc_wait && (wait_cnt_q != 8'hFF)) begin
                wait_cnt_q <= wait_cnt_q + 8'd1;
            end

            if (capture) begin
                result_q <= add_result;
                cout_q   <= add_cout;
            end else if (capture_to) begin
                result_q <= '0;
                cout_q   <= 1'b0;
            end
        end
    end

`ifdef ADD_ARB_TIMEOUT_EN
    logic err_q;

    // Error flag: set by a timeout completion, cleared by a normal one.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (capture) begin
            err_q <= 1'b0;
        end else if (capture_to) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Output decode: adder bus is only driven while an operation is in flight.
    always_comb begin
        add_en  = (state_q == S_ISSUE) || (state_q == S_WAIT);
        add_a   = add_en ? op_a_q : 16'h0000;
        add_b   = add_en ? op_b_q : 16'h0000;
        add_sub = add_en ? op_sub_q : 1'b0;
        done0   = (state_q == S_DONE) && gnt0_q;
        done1   = (state_q == S_DONE) && gnt1_q;
        gnt0    = gnt0_q;
        gnt1    = gnt1_q;
        result  = result_q;
        cout    = cout_q;
    end

endmodule

// File: tb/tb_add_unit_arbiter.sv
// Bench for add_unit_arbiter: a behavioural adder with a programmable ready
// delay, a table of single-operation vectors, and hand-written sequences for
// contention, timeout and reset in WAIT.

module tb_add_unit_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, sub0 = 1'b0, sub1 = 1'b0;
    logic [15:0] a0 = 16'hAAAA, b0 = 16'h5555, a1 = 16'hA5A5, b1 = 16'h5A5A;
    logic        gnt0, gnt1, done0, done1, cout, err, add_en, add_sub;
    logic [15:0] result, add_a, add_b, add_result;
    logic        add_cout, add_ready;

    int   total = 0;
    int   bad = 0;
    int   overlap = 0;
    int   hold = 1;
    logic stuck = 1'b0;
    int   en_cnt = 0;

    add_unit_arbiter #(.MIN_WAIT(2), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .sub0(sub0), .sub1(sub1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .result(result), .cout(cout), .err(err),
        .add_en(add_en), .add_a(add_a), .add_b(add_b), .add_sub(add_sub),
        .add_result(add_result), .add_cout(add_cout), .add_ready(add_ready)
    );

    always #5 clk = ~clk;

    // Adder model: A + (sub ? ~B : B) + sub; ready once enabled longer than hold cycles.
    logic [16:0] sum;
    assign sum        = {1'b0, add_a} + {1'b0, (add_sub ? ~add_b : add_b)} + {16'h0000, add_sub};
    assign add_result = sum[15:0];
    assign add_cout   = sum[16];
    assign add_ready  = stuck | (add_en && (en_cnt > hold));

    always @(posedge clk) begin
        if (add_en) en_cnt <= en_cnt + 1;
        else        en_cnt <= 0;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; stuck = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        r0, r1;
        logic [15:0] a0, b0;
        logic        s0;
        logic [15:0] a1, b1;
        logic        s1;
        int          hold;
        logic        stuck;
        logic        scramble;
        logic        exp_g1;
        logic [15:0] exp_res;
        logic        exp_cout;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input int i);
        vec_t        v;
        int          lat;
        bit          got;
        logic [15:0] ea, eb;
        logic        es;
        v   = vecs[i];
        ea  = v.exp_g1 ? v.a1 : v.a0;
        eb  = v.exp_g1 ? v.b1 : v.b0;
        es  = v.exp_g1 ? v.s1 : v.s0;
        @(negedge clk);
        req0 = v.r0; req1 = v.r1;
        a0 = v.a0; b0 = v.b0; sub0 = v.s0;
        a1 = v.a1; b1 = v.b1; sub1 = v.s1;
        hold = v.hold; stuck = v.stuck;
        lat = 0; got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (gnt0 && gnt1) overlap++;
            if (lat == 1)
                chk($sformatf("vec%0d_issue", i),
                    {28'h0, gnt0, gnt1, add_en, add_sub, add_a, add_b},
                    {28'h0, !v.exp_g1, v.exp_g1, 1'b1, es, ea, eb});
            if (lat == 2 && v.scramble) begin
                a0 = 16'hFFFF; b0 = 16'hFFFF; sub0 = ~v.s0;
                a1 = 16'hFFFF; b1 = 16'hFFFF; sub1 = ~v.s1;
            end
            if (done0 || done1) got = 1'b1;
        end
        chk($sformatf("vec%0d_done_seen", i), 64'(got), 64'd1);
        chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(v.exp_lat));
        chk($sformatf("vec%0d_done_sel", i), {62'h0, done0, done1}, {62'h0, !v.exp_g1, v.exp_g1});
        chk($sformatf("vec%0d_gnt_in_done", i), {62'h0, gnt0, gnt1}, {62'h0, !v.exp_g1, v.exp_g1});
        chk($sformatf("vec%0d_result", i), 64'(result), 64'(v.exp_res));
        chk($sformatf("vec%0d_cout_err", i), {62'h0, cout, err}, {62'h0, v.exp_cout, 1'b0});
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0; stuck = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("vec%0d_idle_after", i),
            {59'h0, gnt0, gnt1, done0, done1, add_en}, 64'h0);
        chk($sformatf("vec%0d_result_held", i), 64'(result), 64'(v.exp_res));
    endtask

    initial begin : main
        int n_done;
        int cyc;
        bit got;

        //           r0    r1    a0       b0       s0    a1       b1       s1    hold   stuck scr   g1    res      cout  lat
        vecs[0] = '{1'b1, 1'b0, 16'h1234, 16'h0FED, 1'b0, 16'h0000, 16'h0000, 1'b0, 1, 1'b0, 1'b0, 1'b0, 16'h2221, 1'b0, 4};
        vecs[1] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0003, 16'h0005, 1'b1, 1, 1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b0, 4};
        vecs[2] = '{1'b1, 1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h7777, 16'h1111, 1'b0, 1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 4};
        vecs[3] = '{1'b1, 1'b1, 16'h2222, 16'h3333, 1'b0, 16'h8000, 16'h0001, 1'b1, 1, 1'b0, 1'b0, 1'b1, 16'h7FFF, 1'b1, 4};
        vecs[4] = '{1'b1, 1'b0, 16'h0005, 16'h0005, 1'b1, 16'h0000, 16'h0000, 1'b0, 0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 4};
        vecs[5] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h00FF, 16'h0001, 1'b0, 3, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b0, 6};
        vecs[6] = '{1'b1, 1'b0, 16'h1000, 16'h0234, 1'b0, 16'h0000, 16'h0000, 1'b0, 6, 1'b0, 1'b1, 1'b0, 16'h1234, 1'b0, 9};

        // Reset state
        do_reset();
        @(posedge clk); #1;
        chk("reset_ctrl", {56'h0, gnt0, gnt1, done0, done1, err, cout, add_en, add_sub}, 64'h0);
        chk("reset_result", 64'(result), 64'h0);
        chk("reset_add_ops", {32'h0, add_a, add_b}, 64'h0);

        // Single operations, ties and ready-delay variants
        for (int i = 0; i < 7; i++) run_vec(i);

        // Contention from reset: both requests held for three operations
        do_reset();
        @(negedge clk);
        req0 = 1'b1; a0 = 16'h0001; b0 = 16'h0001; sub0 = 1'b0;
        req1 = 1'b1; a1 = 16'h0010; b1 = 16'h0001; sub1 = 1'b1;
        hold = 1;
        n_done = 0; cyc = 0;
        while (n_done < 3 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (gnt0 && gnt1) overlap++;
            if (done0 || done1) begin
                chk($sformatf("rr%0d_done_sel", n_done), {62'h0, done0, done1},
                    (n_done == 1) ? 64'h1 : 64'h2);
                chk($sformatf("rr%0d_cycle", n_done), 64'(cyc), 64'(4 + 5 * n_done));
                chk($sformatf("rr%0d_result", n_done), {47'h0, cout, result},
                    (n_done == 1) ? {47'h0, 1'b1, 16'h000F} : {47'h0, 1'b0, 16'h0002});
                n_done++;
            end
        end
        chk("rr_done_count", 64'(n_done), 64'd3);
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); #1;

        // Ready never arrives
        @(negedge clk);
        req0 = 1'b1; a0 = 16'h1111; b0 = 16'h2222; sub0 = 1'b0;
        hold = 100000;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (done0 || done1) got = 1'b1;
        end
`ifdef ADD_ARB_TIMEOUT_EN
        chk("timeout_done_seen", 64'(got), 64'd1);
        chk("timeout_cycle", 64'(cyc), 64'd17);
        chk("timeout_flags", {60'h0, done0, done1, err, cout}, 64'hA);
        chk("timeout_result", 64'(result), 64'h0);
        @(negedge clk);
        req0 = 1'b0;
        @(posedge clk); #1;
`else
        chk("no_timeout_done", 64'(got), 64'd0);
        chk("no_timeout_still_busy", {62'h0, gnt0, add_en}, 64'h3);
        do_reset();
`endif
        hold = 1;

        // Reset in WAIT: prior result is non-zero, then reset on cycle 3
        run_vec(0);
        @(negedge clk);
        req0 = 1'b1; a0 = 16'h4000; b0 = 16'h0001; sub0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rstwait_pre", {62'h0, gnt0, add_en}, 64'h3);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstwait_ctrl", {56'h0, gnt0, gnt1, done0, done1, err, cout, add_en, add_sub}, 64'h0);
        chk("rstwait_result", 64'(result), 64'h0);
        chk("rstwait_add_ops", {32'h0, add_a, add_b}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (done0 || done1) got = 1'b1;
        end
        chk("rstwait_fresh_done", {62'h0, done0, done1}, 64'h2);
        chk("rstwait_fresh_cycle", 64'(cyc), 64'd4);
        chk("rstwait_fresh_result", {47'h0, cout, result}, {47'h0, 1'b0, 16'h4001});
        @(negedge clk);
        req0 = 1'b0;
        @(posedge clk); #1;

        chk("gnt_overlap_cycles", 64'(overlap), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
